// File: rtl/logic_issue_pkg.sv
// Shared types and constants for the logical-unit issue controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents: response FIFO entry type, FIFO depth, and the CMOV opcode the
// controller must recognise to qualify the write-enable.
package logic_issue_pkg;

   // Default tag width; the controller's TAG_W parameter must match this value
   // because the FIFO entry layout is fixed here.
   localparam int RSP_TAG_W = 6;

   // Response buffer depth; also bounds outstanding work (FIFO + in-flight).
   localparam int RSP_DEPTH = 2;

   // Logical-unit opcode for conditional move (same encoding as the unit).
   localparam logic [2:0] LOG_CMOV = 3'd6;

   typedef struct packed {
      logic                 pipe;
      logic [RSP_TAG_W-1:0] tag;
      logic [63:0]          result;
      logic                 cmp;
      logic                 wr_en;
   } rsp_entry_t;

endpackage

// File: rtl/logic_rsp_fifo.sv
// 2-entry synchronous FIFO holding logical-unit responses for writeback.
// Latency: push visible at head the cycle after it is written.
// Backpressure: caller must not push when full unless popping the same cycle.
//
// Ports: clk, reset (sync, active-high); push_i/push_dat_i write an entry;
// pop_i removes the head; head_o is the oldest entry; count_o is occupancy.
module logic_rsp_fifo
   import logic_issue_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       push_i,
   input  rsp_entry_t push_dat_i,
   input  logic       pop_i,
   output rsp_entry_t head_o,
   output logic [1:0] count_o
);

   rsp_entry_t mem_q [RSP_DEPTH];
   // Depth is 2, so a single bit addresses an entry.
   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic [1:0] count_q;
   logic       do_push;
   logic       do_pop;

   assign do_pop  = pop_i & (count_q != 2'd0);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push_i & ((count_q != 2'(RSP_DEPTH)) | do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < RSP_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + 2'(do_push) - 2'(do_pop);
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/logic_issue_ctrl.sv
// Shares one logical unit between two issue pipes; tracks the in-flight op and buffers results.
// Latency: grant in T, unit returns in T+1, response visible from T+2; 1 op/cycle sustained.
// Backpressure: grants stop once FIFO entries plus in-flight op (minus a same-cycle pop) reach 2.
//
// Ports: clk, reset (sync, active-high); req_* per-pipe request in (valid/ready);
// lu_* drive and return from the logical unit; rsp_* response out (valid/ready).
// Build option: LOGIC_ISSUE_RR_EN selects round-robin arbitration; otherwise
// pipe 0 has fixed priority.
module logic_issue_ctrl
   import logic_issue_pkg::*;
#(
   parameter int TAG_W = RSP_TAG_W
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [63:0]      req_op_a   [2],
   input  logic [63:0]      req_op_b   [2],
   input  logic [2:0]       req_log_op [2],
   input  logic [2:0]       req_cmp_op [2],
   input  logic [TAG_W-1:0] req_tag    [2],
   output logic             lu_enable,
   output logic [63:0]      lu_op_a,
   output logic [63:0]      lu_op_b,
   output logic [2:0]       lu_log_op,
   output logic [2:0]       lu_log_cmp_op,
   input  logic             lu_rvalid,
   input  logic             lu_cmp_result,
   input  logic [63:0]      lu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_pipe,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [63:0]      rsp_result,
   output logic             rsp_cmp,
   output logic             rsp_wr_en
);

   logic [1:0]       fifo_count;
   rsp_entry_t       fifo_head;
   rsp_entry_t       push_dat;
   logic             push;
   logic             deq;
   logic [2:0]       occupancy;
   logic             can_issue;
   logic             grant;
   logic             win_pipe;

   logic             inflight_q, inflight_d;
   logic             pipe_q,     pipe_d;
   logic             is_cmov_q,  is_cmov_d;
   logic [TAG_W-1:0] tag_q,      tag_d;

   // ---------------- issue condition ----------------
   assign rsp_valid = (fifo_count != 2'd0);
   assign deq       = rsp_valid & rsp_ready;
   // deq implies fifo_count >= 1, so this never underflows.
   assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, deq};
   // No grants while reset is asserted, so nothing transfers during reset.
   assign can_issue = ~reset & (occupancy < 3'(RSP_DEPTH));
   assign grant     = can_issue & (|req_valid);

   // ---------------- arbitration ----------------
`ifdef LOGIC_ISSUE_RR_EN
   logic rr_q, rr_d;

   // Pointer picks the winner only on conflict; a lone requester always wins.
   assign win_pipe = (req_valid == 2'b11) ? rr_q : ~req_valid[0];
   // Flip after every grant regardless of which pipe won.
   assign rr_d     = grant ? ~rr_q : rr_q;

   always_ff @(posedge clk) begin
      if (reset) rr_q <= 1'b0;
      else       rr_q <= rr_d;
   end
`else
   assign win_pipe = ~req_valid[0];
`endif

   assign req_ready = grant ? (win_pipe ? 2'b10 : 2'b01) : 2'b00;

   // ---------------- unit drive ----------------
   always_comb begin
      lu_enable     = 1'b0;
      lu_op_a       = '0;
      lu_op_b       = '0;
      lu_log_op     = '0;
      lu_log_cmp_op = '0;
      if (grant) begin
         lu_enable     = 1'b1;
         lu_op_a       = req_op_a[win_pipe];
         lu_op_b       = req_op_b[win_pipe];
         lu_log_op     = req_log_op[win_pipe];
         lu_log_cmp_op = req_cmp_op[win_pipe];
      end
   end

   // ---------------- in-flight tracker ----------------
   // A return with nothing outstanding (e.g. straight after reset) is dropped.
   assign push = lu_rvalid & inflight_q;

   always_comb begin
      inflight_d = inflight_q;
      pipe_d     = pipe_q;
      is_cmov_d  = is_cmov_q;
      tag_d      = tag_q;
      if (push) inflight_d = 1'b0;
      // A grant in the return cycle keeps the tracker busy with the new op.
      if (grant) begin
         inflight_d = 1'b1;
         pipe_d     = win_pipe;
         is_cmov_d  = (req_log_op[win_pipe] == LOG_CMOV);
         tag_d      = req_tag[win_pipe];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         inflight_q <= 1'b0;
         pipe_q     <= 1'b0;
         is_cmov_q  <= 1'b0;
         tag_q      <= '0;
      end else begin
         inflight_q <= inflight_d;
         pipe_q     <= pipe_d;
         is_cmov_q  <= is_cmov_d;
         tag_q      <= tag_d;
      end
   end

   // Non-CMOV ops always write; CMOV writes only when the compare holds.
   always_comb begin
      push_dat        = '0;
      push_dat.pipe   = pipe_q;
      push_dat.tag    = tag_q;
      push_dat.result = lu_result;
      push_dat.cmp    = lu_cmp_result;
      push_dat.wr_en  = ~is_cmov_q | lu_cmp_result;
   end

   logic_rsp_fifo u_rsp_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (push),
      .push_dat_i (push_dat),
      .pop_i      (deq),
      .head_o     (fifo_head),
      .count_o    (fifo_count)
   );

   // Data fields read as zero whenever no response is presented.
   assign rsp_pipe   = rsp_valid & fifo_head.pipe;
   assign rsp_tag    = rsp_valid ? fifo_head.tag    : '0;
   assign rsp_result = rsp_valid ? fifo_head.result : '0;
   assign rsp_cmp    = rsp_valid & fifo_head.cmp;
   assign rsp_wr_en  = rsp_valid & fifo_head.wr_en;

endmodule

// File: tb/tb_logic_issue_ctrl.sv
// Testbench for logic_issue_ctrl: directed vector table, multi-cycle corner
// sequences, then random traffic against a queue-based reference model.
// The bench also plays the logical unit, answering one cycle after each issue.
`timescale 1ns/1ps
module tb_logic_issue_ctrl;
   import logic_issue_pkg::*;

   localparam int TAG_W = 6;

   // opcode encodings used by the unit model
   localparam bit [2:0] OP_AND = 3'd0, OP_BIC = 3'd1, OP_BIS = 3'd2, OP_XOR = 3'd3,
                        OP_ORNOT = 3'd4, OP_EQV = 3'd5;
   localparam bit [2:0] CMP_EQ = 3'd0, CMP_NE = 3'd1, CMP_LT = 3'd2;

   logic             clk = 1'b0;
   logic             reset;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [63:0]      req_op_a   [2];
   logic [63:0]      req_op_b   [2];
   logic [2:0]       req_log_op [2];
   logic [2:0]       req_cmp_op [2];
   logic [TAG_W-1:0] req_tag    [2];
   logic             lu_enable;
   logic [63:0]      lu_op_a, lu_op_b;
   logic [2:0]       lu_log_op, lu_log_cmp_op;
   logic             lu_rvalid, lu_cmp_result;
   logic [63:0]      lu_result;
   logic             rsp_valid, rsp_ready, rsp_pipe, rsp_cmp, rsp_wr_en;
   logic [TAG_W-1:0] rsp_tag;
   logic [63:0]      rsp_result;

   logic_issue_ctrl #(.TAG_W(TAG_W)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op_a(req_op_a), .req_op_b(req_op_b),
      .req_log_op(req_log_op), .req_cmp_op(req_cmp_op), .req_tag(req_tag),
      .lu_enable(lu_enable), .lu_op_a(lu_op_a), .lu_op_b(lu_op_b),
      .lu_log_op(lu_log_op), .lu_log_cmp_op(lu_log_cmp_op),
      .lu_rvalid(lu_rvalid), .lu_cmp_result(lu_cmp_result), .lu_result(lu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_pipe(rsp_pipe),
      .rsp_tag(rsp_tag), .rsp_result(rsp_result), .rsp_cmp(rsp_cmp),
      .rsp_wr_en(rsp_wr_en)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- logical unit behaviour ----------------
   function automatic void lu_model(input bit [2:0] op, input bit [2:0] cop,
                                    input bit [63:0] a, input bit [63:0] b,
                                    output bit [63:0] r, output bit c);
      case (cop)
         3'd0:    c = (a == 64'd0);
         3'd1:    c = (a != 64'd0);
         3'd2:    c = ($signed(a) <  0);
         3'd3:    c = ($signed(a) <= 0);
         3'd4:    c = ($signed(a) >  0);
         3'd5:    c = ($signed(a) >= 0);
         3'd6:    c = a[0];
         default: c = ~a[0];
      endcase
      case (op)
         OP_AND:   r = a & b;
         OP_BIC:   r = a & ~b;
         OP_BIS:   r = a | b;
         OP_XOR:   r = a ^ b;
         OP_ORNOT: r = a | ~b;
         OP_EQV:   r = ~(a ^ b);
         LOG_CMOV: r = b;
         default:  r = a;
      endcase
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      bit             pipe;
      bit [TAG_W-1:0] tag;
      bit [63:0]      res;
      bit             cmp;
      bit             wr;
   } ent_t;

   ent_t           m_q[$];        // responses waiting for writeback
   bit             m_inf;         // one op issued, result not yet back
   bit             m_inf_pipe;
   bit [TAG_W-1:0] m_inf_tag;
   bit             m_inf_cmov;
   bit             m_ptr;         // round-robin preference
   bit             pend_v;        // unit answer due next cycle
   bit [63:0]      pend_r;
   bit             pend_c;
   logic [1:0]     last_ready;
   logic           last_lu_en;
   bit [TAG_W-1:0] popped[$];

   task automatic model_clear();
      m_q.delete();
      m_inf  = 1'b0;
      m_ptr  = 1'b0;
      pend_v = 1'b0;
   endtask

   // Called at a negedge with inputs already driven; checks this cycle's
   // outputs against the model, advances one clock, then drives the unit reply.
   task automatic cycle();
      ent_t      h;
      bit        deq, g, w;
      int        occ;
      bit [1:0]  exp_ready;
      bit [63:0] ea, eb;
      bit [2:0]  eop, ecop;
      #1;
      h = '{default: 0};
      if (m_q.size() != 0) h = m_q[0];
      chk("rsp_valid",  rsp_valid,  m_q.size() != 0);
      chk("rsp_pipe",   rsp_pipe,   h.pipe);
      chk("rsp_tag",    rsp_tag,    h.tag);
      chk("rsp_result", rsp_result, h.res);
      chk("rsp_cmp",    rsp_cmp,    h.cmp);
      chk("rsp_wr_en",  rsp_wr_en,  h.wr);
      deq = (m_q.size() != 0) && rsp_ready;
      occ = m_q.size() + int'(m_inf) - int'(deq);
      g   = (occ < 2) && (req_valid != 2'b00);
`ifdef LOGIC_ISSUE_RR_EN
      w = (req_valid == 2'b11) ? m_ptr : (req_valid[1] & ~req_valid[0]);
`else
      w = ~req_valid[0];
`endif
      exp_ready = g ? (w ? 2'b10 : 2'b01) : 2'b00;
      ea = g ? req_op_a[w] : 64'd0;
      eb = g ? req_op_b[w] : 64'd0;
      eop  = g ? req_log_op[w] : 3'd0;
      ecop = g ? req_cmp_op[w] : 3'd0;
      chk("req_ready",     req_ready,     exp_ready);
      chk("lu_enable",     lu_enable,     g);
      chk("lu_op_a",       lu_op_a,       ea);
      chk("lu_op_b",       lu_op_b,       eb);
      chk("lu_log_op",     lu_log_op,     eop);
      chk("lu_log_cmp_op", lu_log_cmp_op, ecop);
      last_ready = req_ready;
      last_lu_en = lu_enable;
      if (rsp_valid && rsp_ready) popped.push_back(rsp_tag);
      // unit reply for next cycle
      pend_v = g;
      if (g) lu_model(eop, ecop, ea, eb, pend_r, pend_c);
      // model update
      if (deq) void'(m_q.pop_front());
      if (lu_rvalid && m_inf) begin
         m_q.push_back('{pipe: m_inf_pipe, tag: m_inf_tag, res: lu_result,
                         cmp: lu_cmp_result, wr: (!m_inf_cmov) || lu_cmp_result});
         m_inf = 1'b0;
      end
      if (g) begin
         m_inf      = 1'b1;
         m_inf_pipe = w;
         m_inf_tag  = req_tag[w];
         m_inf_cmov = (req_log_op[w] == LOG_CMOV);
         m_ptr      = ~m_ptr;
      end
      @(posedge clk);
      @(negedge clk);
      lu_rvalid     = pend_v;
      lu_result     = pend_v ? pend_r : 64'd0;
      lu_cmp_result = pend_v ? pend_c : 1'b0;
   endtask

   task automatic set_req(input bit p, input bit [2:0] op, input bit [2:0] cop,
                          input bit [63:0] a, input bit [63:0] b, input bit [TAG_W-1:0] t);
      req_op_a[p]   = a;
      req_op_b[p]   = b;
      req_log_op[p] = op;
      req_cmp_op[p] = cop;
      req_tag[p]    = t;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit             pipe;
      bit [2:0]       op;
      bit [2:0]       cop;
      bit [63:0]      a;
      bit [63:0]      b;
      bit [TAG_W-1:0] tag;
      bit [63:0]      exp_res;
      bit             exp_cmp;
      bit             exp_wr;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{1'b0, OP_BIS,   CMP_EQ, 64'hF0,   64'h0F,   6'd5,  64'hFF,    1'b0, 1'b1};
      vecs[1] = '{1'b0, LOG_CMOV, CMP_EQ, 64'h0,    64'h1234, 6'd9,  64'h1234,  1'b1, 1'b1};
      vecs[2] = '{1'b1, LOG_CMOV, CMP_EQ, 64'h7,    64'h1234, 6'd10, 64'h1234,  1'b0, 1'b0};
      vecs[3] = '{1'b1, OP_AND,   CMP_EQ, 64'hFF00, 64'h0FF0, 6'd11, 64'h0F00,  1'b0, 1'b1};
      vecs[4] = '{1'b0, OP_XOR,   CMP_NE, 64'hFFFF, 64'h00FF, 6'd12, 64'hFF00,  1'b1, 1'b1};
      vecs[5] = '{1'b1, LOG_CMOV, CMP_NE, 64'h3,    64'hABCD, 6'd13, 64'hABCD,  1'b1, 1'b1};
      vecs[6] = '{1'b0, OP_EQV,   CMP_EQ, 64'h0,    64'h0,    6'd14, {64{1'b1}}, 1'b1, 1'b1};
      vecs[7] = '{1'b0, LOG_CMOV, CMP_LT, 64'h5,    64'h77,   6'd15, 64'h77,    1'b0, 1'b0};

      reset = 1'b1;
      req_valid = 2'b11;
      rsp_ready = 1'b0;
      lu_rvalid = 1'b0; lu_cmp_result = 1'b0; lu_result = 64'd0;
      for (int p = 0; p < 2; p++) set_req(p[0], OP_AND, CMP_EQ, 64'h1, 64'h2, 6'd1);
      model_clear();
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_lu_enable", lu_enable, 1'b0);
      reset = 1'b0;
      req_valid = 2'b00;
      #1;
      chk("rst_rsp_valid",  rsp_valid,  1'b0);
      chk("rst_rsp_tag",    rsp_tag,    '0);
      chk("rst_rsp_result", rsp_result, 64'd0);
      chk("rst_lu_op_a",    lu_op_a,    64'd0);
      @(negedge clk);

      // --- contention, both pipes valid every cycle ---
      rsp_ready = 1'b1;
      req_valid = 2'b11;
      for (int k = 0; k < 6; k++) begin
         cycle();
`ifdef LOGIC_ISSUE_RR_EN
         chk("contention_grant", last_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
`else
         chk("contention_grant", last_ready, 2'b01);
`endif
      end
      req_valid = 2'b00;
      repeat (3) cycle();

      // --- vector table: isolated ops ---
      for (int i = 0; i < 8; i++) begin
         req_valid = 2'b00;
         set_req(vecs[i].pipe, vecs[i].op, vecs[i].cop, vecs[i].a, vecs[i].b, vecs[i].tag);
         req_valid[vecs[i].pipe] = 1'b1;
         cycle();
         chk("vec_lu_enable", last_lu_en, 1'b1);
         req_valid = 2'b00;
         cycle();
         #1;
         chk("vec_rsp_valid",  rsp_valid,  1'b1);
         chk("vec_rsp_pipe",   rsp_pipe,   vecs[i].pipe);
         chk("vec_rsp_tag",    rsp_tag,    vecs[i].tag);
         chk("vec_rsp_result", rsp_result, vecs[i].exp_res);
         chk("vec_rsp_cmp",    rsp_cmp,    vecs[i].exp_cmp);
         chk("vec_rsp_wr_en",  rsp_wr_en,  vecs[i].exp_wr);
         cycle();
      end

      // --- backpressure: pipe 0 streaming, writeback stalled ---
      begin
         int grants;
         grants = 0;
         rsp_ready = 1'b0;
         req_valid = 2'b01;
         for (int k = 0; k < 6; k++) begin
            set_req(1'b0, OP_BIS, CMP_EQ, 64'(k), 64'h100, 6'(20 + k));
            if (k >= 2) begin
               #1;
               chk("bp_head_tag", rsp_tag, 6'd20);
            end
            cycle();
            if (last_ready[0]) grants++;
         end
         chk("bp_grant_count", grants, 2);
         popped.delete();
         rsp_ready = 1'b1;
         set_req(1'b0, OP_BIS, CMP_EQ, 64'h9, 64'h100, 6'd26);
         #1;
         chk("bp_pop_and_grant", req_ready, 2'b01);
         cycle();
         req_valid = 2'b00;
         repeat (4) cycle();
         chk("bp_pop_count", popped.size(), 3);
         if (popped.size() == 3) begin
            chk("bp_order0", popped[0], 6'd20);
            chk("bp_order1", popped[1], 6'd21);
            chk("bp_order2", popped[2], 6'd26);
         end
      end

      // --- reset while an op is in flight ---
      rsp_ready = 1'b1;
      req_valid = 2'b01;
      set_req(1'b0, OP_XOR, CMP_EQ, 64'h3, 64'h5, 6'd30);
      cycle();                 // grant at T; unit answers during T+1
      req_valid = 2'b00;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      lu_rvalid = 1'b1;        // late/stray answer right after reset
      lu_result = 64'hDEAD;
      lu_cmp_result = 1'b1;
      #1;
      chk("rst_flight_t2", rsp_valid, 1'b0);
      cycle();
      #1;
      chk("rst_flight_t3", rsp_valid, 1'b0);
      cycle();
      req_valid = 2'b01;
      set_req(1'b0, OP_BIS, CMP_EQ, 64'h10, 64'h01, 6'd31);
      cycle();
      req_valid = 2'b00;
      cycle();
      #1;
      chk("post_rst_valid",  rsp_valid,  1'b1);
      chk("post_rst_tag",    rsp_tag,    6'd31);
      chk("post_rst_result", rsp_result, 64'h11);
      cycle();

      // --- stray return with nothing in flight ---
      lu_rvalid = 1'b1;
      lu_result = 64'hBEEF;
      cycle();
      #1;
      chk("stray_rsp_valid", rsp_valid, 1'b0);
      cycle();

      // --- random traffic against the model ---
      for (int c = 0; c < 3000; c++) begin
         req_valid = 2'($urandom_range(0, 3));
         for (int p = 0; p < 2; p++) begin
            bit [63:0] a;
            a = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            set_req(p[0], 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    a, {$urandom, $urandom}, 6'($urandom));
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         if (!lu_rvalid && $urandom_range(0, 7) == 0) begin
            lu_rvalid     = 1'b1;
            lu_result     = {$urandom, $urandom};
            lu_cmp_result = 1'($urandom);
         end
         cycle();
      end
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      repeat (4) cycle();
      chk("final_drained", rsp_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/logic_issue_ctrl.md
# logic_issue_ctrl

Issue controller that shares the single logical unit (AND/BIC/BIS/XOR/ORNOT/EQV/CMOV plus conditional-compare) between two integer issue pipes. It arbitrates requests, drives the unit's `enable`/operand/opcode inputs, and tracks the one in-flight operation. It buffers results in a 2-entry response FIFO with backpressure, and computes the CMOV write-enable from the unit's compare result. It sits between the issue stage and the logical unit; responses go to writeback.

## Interface
- `TAG_W`, default 6: width of the destination/ROB tag carried with each request.
- `clk  in  1  clock`
- `reset  in  1  synchronous, active-high reset`
- `req_valid  in  2`: per-pipe request valid (bit i = pipe i).
- `req_ready  out  2`: per-pipe grant. A request transfers when `valid & ready`.
- `req_op_a[2]`, `req_op_b[2]  in  64 each`: operands.
- `req_log_op[2]`, `req_cmp_op[2]  in  3 each`: `LOG_*` / `LOG_CMP_*` codes from defines.vh.
- `req_tag[2]  in  TAG_W`: tag returned with the response.
- `lu_enable  out  1`, `lu_op_a`/`lu_op_b  out  64`, `lu_log_op`/`lu_log_cmp_op  out  3`: drive the logical unit.
- `lu_rvalid  in  1`, `lu_cmp_result  in  1`, `lu_result  in  64`: returned by the logical unit.
- `rsp_valid  out  1`, `rsp_ready  in  1`: response handshake.
- `rsp_pipe  out  1`: originating pipe.
- `rsp_tag  out  TAG_W`.
- `rsp_result  out  64`.
- `rsp_cmp  out  1`.
- `rsp_wr_en  out  1`.

## Operation
- **Issue condition:** `can_issue = (fifo_count + inflight - deq) < 2`, where `deq = rsp_valid & rsp_ready`.
- **Granting:** when `can_issue` is high, at most one `req_ready` bit is asserted, and only for a valid requester. `req_ready` is combinational from `req_valid`, the arbiter state and FIFO state. It is never asserted when `can_issue` is 0.
- **On grant:**
  - `lu_enable = 1` in the same cycle.
  - The `lu_*` operand and opcode outputs are muxed combinationally from the granted pipe.
  - When there is no grant, `lu_*` operands and opcodes are 0.
  - Pipe id, tag and `is_cmov` (`log_op == LOG_CMOV`) are registered into the in-flight tracker.
  - `inflight` is set to 1.
- **On `lu_rvalid`:** push {pipe, tag, `lu_result`, `lu_cmp_result`, `wr_en`} into the FIFO, where `wr_en = ~is_cmov | lu_cmp_result`.
  - `inflight` clears unless a new grant occurs in the same cycle; issue and return in the same cycle keep `inflight = 1`.
- **Stray return:** `lu_rvalid` while `inflight == 0` is ignored and not pushed.
- **Response output:** `rsp_*` presents the FIFO head. `rsp_valid = (fifo_count != 0)`. The head holds stable while `rsp_valid & ~rsp_ready`.
- **FIFO ordering:** push and pop in the same cycle are both honoured, and the count is unchanged. The FIFO never overflows because of the issue condition.

## Timing
- **Latency:** grant in cycle T; `lu_rvalid` in T+1; `rsp_valid` from T+2. Minimum request-to-response latency is 2 cycles.
- **Throughput:** 1 op/cycle sustained while `rsp_ready = 1`.
- **Stall pattern with `rsp_ready` held 0:** at most 2 ops are accepted, then `req_ready = 0` until a pop occurs.
- **Pop to reissue:** a grant is allowed in the same cycle as a pop that frees space.
- **Reset values:**
  - `req_ready = 0`, `lu_enable = 0`, all `lu_*` outputs 0.
  - `rsp_valid = 0`; `rsp_pipe`, `rsp_tag`, `rsp_result`, `rsp_cmp`, `rsp_wr_en` all 0.
  - FIFO empty, `inflight = 0`, round-robin pointer = 0.
- **Reset mid-operation:** the in-flight op and FIFO contents are discarded. `lu_rvalid` in the cycle after reset deasserts is ignored because `inflight = 0`.

## Configuration
- **`LOGIC_ISSUE_RR_EN` defined:** round-robin arbitration.
  - 1-bit priority pointer; the pipe equal to the pointer wins a conflict.
  - The pointer flips to the other pipe after every grant, whichever pipe was granted.
- **Not defined:** fixed priority, pipe 0 always wins; no pointer register exists.
- The FIFO, CMOV and handshake behaviour is identical in both builds.

## Structure
- **Package `logic_issue_pkg`:** `rsp_entry_t` struct {pipe, tag, result[63:0], cmp, wr_en}, parameterised by `TAG_W` via a package localparam default; and the `RSP_DEPTH = 2` constant.
- `LOG_*` codes remain in defines.vh.
- **Sub-module `logic_rsp_fifo`:** 2-entry synchronous FIFO of `rsp_entry_t` with push/pop/count and synchronous reset.
- The arbiter and in-flight tracker stay inline.

## Test plan
- **Single request:** pipe0 BIS, a=0xF0, b=0x0F, tag 5, `rsp_ready = 1`.
  - `lu_enable` at T; `rsp_valid` at T+2 with result 0xFF, pipe 0, tag 5, `wr_en = 1`.
- **CMOV:**
  - CMOV, cmp EQ, a=0, b=0x1234 -> result 0x1234, `rsp_cmp = 1`, `wr_en = 1`.
  - Same with a=7 -> `rsp_cmp = 0`, `wr_en = 0`.
- **Contention:** both pipes valid continuously, `rsp_ready = 1`.
  - With RR: grants alternate 0,1,0,1 at 1/cycle.
  - Without RR: pipe 0 granted every cycle, pipe 1 never.
- **Backpressure:** `rsp_ready = 0`, pipe0 streaming.
  - Exactly 2 grants, then `req_ready = 0`; head stable.
  - Raise `rsp_ready` -> one pop and one grant in the same cycle; responses stay in order by tag.
- **Reset mid-flight:** grant at T, `reset` at T+1.
  - `rsp_valid = 0` at T+2 and after; the next request after reset completes normally.
- **Stray `lu_rvalid`:** pulse `lu_rvalid` with `inflight = 0` -> FIFO count stays 0 and `rsp_valid` stays 0.
